// File: rtl/vehicle_sensor_if_if.sv
// Signal bundle between the loop-detector front end and the sensor-mode controller.
// The slave modport is the front end; the master modport is the controller/stimulus side.
interface vehicle_sensor_if_if;
    logic       enable_sensor_mode;
    logic       CAR_RAW;
    logic       S0;
    logic       count_clr;
    logic       SET_srl;
    logic       car_waiting;
    logic [3:0] car_count;

    modport master (
        output enable_sensor_mode,
        output CAR_RAW,
        output S0,
        output count_clr,
        input  SET_srl,
        input  car_waiting,
        input  car_count
    );

    modport slave (
        input  enable_sensor_mode,
        input  CAR_RAW,
        input  S0,
        input  count_clr,
        output SET_srl,
        output car_waiting,
        output car_count
    );
endinterface

// File: rtl/vehicle_sensor_if.sv
// Side-street vehicle detector: synchronize and debounce the loop input, raise one
// SET_srl per controller service cycle, then hold off before re-arming.
//
// state      | meaning
// IDLE       | armed, waiting for a synchronized vehicle sample
// QUAL       | counting consecutive high samples
// FIRE       | one-cycle service request, count the vehicle
// WAIT_START | request issued, controller still at rest
// SERVING    | controller has left rest, waiting for it to return
// HOLDOFF    | dead time after service before re-arming
module vehicle_sensor_if #(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int HOLDOFF_CYCLES  = 8
) (
    input logic                 CLOCK,
    input logic                 RESET,
    vehicle_sensor_if_if.slave  bus
);
    localparam int CNT_MAX = ((DEBOUNCE_CYCLES > HOLDOFF_CYCLES) ? DEBOUNCE_CYCLES : HOLDOFF_CYCLES) - 1;
    localparam int CNT_W   = (CNT_MAX < 2) ? 1 : $clog2(CNT_MAX + 1);
    localparam logic [CNT_W-1:0] DEB_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] HO_LAST  = CNT_W'(HOLDOFF_CYCLES - 1);

    typedef enum logic [2:0] {
        IDLE       = 3'd0,
        QUAL       = 3'd1,
        FIRE       = 3'd2,
        WAIT_START = 3'd3,
        SERVING    = 3'd4,
        HOLDOFF    = 3'd5
    } state_t;

    state_t           state, state_next;
    logic [CNT_W-1:0] cnt, cnt_next;
    logic             sync1, car_s;
    logic [3:0]       car_count;
    logic             fire_inc;

    always_ff @(posedge CLOCK or posedge RESET) begin
        if (RESET) begin
            sync1 <= 1'b0;
            car_s <= 1'b0;
        end else begin
            sync1 <= bus.CAR_RAW;
            car_s <= sync1;
        end
    end

    always_ff @(posedge CLOCK or posedge RESET) begin
        if (RESET) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
        end
    end

    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        if (!bus.enable_sensor_mode) begin
            state_next = IDLE;
            cnt_next   = '0;
        end else begin
            case (state)
                IDLE: begin
                    if (car_s) begin
                        state_next = QUAL;
                        cnt_next   = CNT_W'(1);
                    end
                end
                QUAL: begin
                    if (!car_s) begin
                        state_next = IDLE;
                        cnt_next   = '0;
                    end else if (cnt == DEB_LAST) begin
                        state_next = FIRE;
                    end else begin
                        cnt_next = cnt + CNT_W'(1);
                    end
                end
                FIRE: state_next = WAIT_START;
                WAIT_START: begin
                    if (!bus.S0) state_next = SERVING;
                end
                SERVING: begin
                    if (bus.S0) begin
                        state_next = HOLDOFF;
                        cnt_next   = '0;
                    end
                end
                HOLDOFF: begin
                    // car_s deliberately ignored; a lingering vehicle re-qualifies from IDLE
                    if (cnt == HO_LAST) begin
                        state_next = IDLE;
                        cnt_next   = '0;
                    end else begin
                        cnt_next = cnt + CNT_W'(1);
                    end
                end
                default: begin
                    state_next = IDLE;
                    cnt_next   = '0;
                end
            endcase
        end
    end

    assign fire_inc = (state == FIRE) && bus.enable_sensor_mode;

    // A clear coinciding with a request still counts that vehicle.
    always_ff @(posedge CLOCK or posedge RESET) begin
        if (RESET) begin
            car_count <= 4'd0;
        end else if (bus.count_clr) begin
            car_count <= fire_inc ? 4'd1 : 4'd0;
        end else if (fire_inc && (car_count != 4'd15)) begin
            car_count <= car_count + 4'd1;
        end
    end

    assign bus.SET_srl     = (state == FIRE);
    assign bus.car_waiting = (state == FIRE) || (state == WAIT_START) || (state == SERVING);
    assign bus.car_count   = car_count;
endmodule

// File: tb/tb_vehicle_sensor_if.sv
// Directed bench for vehicle_sensor_if with default parameters (debounce 4, holdoff 8).
module tb_vehicle_sensor_if;
    logic CLOCK;
    logic RESET;
    int   checks;
    int   failures;
    int   exp_count;

    vehicle_sensor_if_if bus();

    vehicle_sensor_if #(.DEBOUNCE_CYCLES(4), .HOLDOFF_CYCLES(8)) dut (
        .CLOCK (CLOCK),
        .RESET (RESET),
        .bus   (bus)
    );

    always #5 CLOCK = ~CLOCK;

    task automatic step();
        @(posedge CLOCK);
        @(negedge CLOCK);
    endtask

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic wait_fire(input string tag);
        for (int k = 0; k < 20 && bus.SET_srl !== 1'b1; k++) step();
        chk(tag, 8'(bus.SET_srl), 8'd1);
    endtask

    task automatic vehicle(input logic clr);
        bus.CAR_RAW = 1'b1;
        wait_fire("fire_seen");
        bus.count_clr = clr;
        step();
        bus.count_clr = 1'b0;
        bus.CAR_RAW = 1'b0;
        bus.enable_sensor_mode = 1'b0;
        step();
        bus.enable_sensor_mode = 1'b1;
    endtask

    initial begin
        checks = 0;
        failures = 0;
        CLOCK = 1'b0;
        RESET = 1'b1;
        bus.enable_sensor_mode = 1'b1;
        bus.CAR_RAW = 1'b0;
        bus.S0 = 1'b1;
        bus.count_clr = 1'b0;
        step();
        step();
        chk("rst_set", 8'(bus.SET_srl), 8'd0);
        chk("rst_wait", 8'(bus.car_waiting), 8'd0);
        chk("rst_count", 8'(bus.car_count), 8'd0);
        RESET = 1'b0;
        step(); step(); step();

        // three qualifying samples then gone: no request
        bus.CAR_RAW = 1'b1;
        step(); step(); step();
        bus.CAR_RAW = 1'b0;
        for (int i = 0; i < 8; i++) begin
            step();
            chk("abort_set", 8'(bus.SET_srl), 8'd0);
        end
        chk("abort_wait", 8'(bus.car_waiting), 8'd0);
        chk("abort_count", 8'(bus.car_count), 8'd0);

        // latency from raw edge before edge 0: request between edges 5 and 6
        bus.CAR_RAW = 1'b1;
        for (int i = 0; i <= 6; i++) begin
            step();
            chk("lat_set", 8'(bus.SET_srl), 8'(i == 5));
            chk("lat_wait", 8'(bus.car_waiting), 8'(i >= 5));
            chk("lat_count", 8'(bus.car_count), 8'(i >= 6));
        end

        // full service cycle with vehicle still present
        bus.S0 = 1'b0;
        for (int i = 0; i < 20; i++) begin
            step();
            chk("srv_wait", 8'(bus.car_waiting), 8'd1);
            chk("srv_set", 8'(bus.SET_srl), 8'd0);
        end
        bus.S0 = 1'b1;
        step();
        chk("fall_wait", 8'(bus.car_waiting), 8'd0);
        for (int i = 1; i <= 12; i++) begin
            step();
            chk("ho_set", 8'(bus.SET_srl), 8'(i == 12));
            chk("ho_wait", 8'(bus.car_waiting), 8'(i == 12));
        end
        step();
        chk("cycle_count", 8'(bus.car_count), 8'd2);

        // enable dropped during QUAL
        bus.enable_sensor_mode = 1'b0;
        step();
        bus.enable_sensor_mode = 1'b1;
        step(); step();
        bus.enable_sensor_mode = 1'b0;
        step();
        chk("q_set", 8'(bus.SET_srl), 8'd0);
        chk("q_wait", 8'(bus.car_waiting), 8'd0);
        chk("q_count", 8'(bus.car_count), 8'd2);
        for (int i = 0; i < 3; i++) begin
            step();
            chk("dis_set", 8'(bus.SET_srl), 8'd0);
        end
        bus.enable_sensor_mode = 1'b1;
        for (int i = 0; i <= 4; i++) begin
            step();
            chk("reen_set", 8'(bus.SET_srl), 8'(i == 3));
        end
        chk("reen_count", 8'(bus.car_count), 8'd3);

        // enable dropped during SERVING
        bus.S0 = 1'b0;
        step();
        chk("s_wait_before", 8'(bus.car_waiting), 8'd1);
        bus.enable_sensor_mode = 1'b0;
        step();
        chk("s_wait", 8'(bus.car_waiting), 8'd0);
        chk("s_set", 8'(bus.SET_srl), 8'd0);
        chk("s_count", 8'(bus.car_count), 8'd3);
        bus.enable_sensor_mode = 1'b1;
        bus.CAR_RAW = 1'b0;
        bus.S0 = 1'b1;
        step(); step(); step();

        // saturation at 15, then clear coincident with a request
        bus.count_clr = 1'b1;
        step();
        bus.count_clr = 1'b0;
        chk("clr_count", 8'(bus.car_count), 8'd0);
        exp_count = 0;
        for (int v = 0; v < 16; v++) begin
            vehicle(1'b0);
            exp_count = (exp_count < 15) ? exp_count + 1 : 15;
            chk("sat_count", 8'(bus.car_count), 8'(exp_count));
        end
        vehicle(1'b1);
        chk("clr_fire_count", 8'(bus.car_count), 8'd1);

        // asynchronous reset in the FIRE cycle
        bus.CAR_RAW = 1'b1;
        wait_fire("rf_fire_seen");
        #2 RESET = 1'b1;
        #1;
        chk("rf_set", 8'(bus.SET_srl), 8'd0);
        chk("rf_wait", 8'(bus.car_waiting), 8'd0);
        chk("rf_count", 8'(bus.car_count), 8'd0);
        @(negedge CLOCK);
        RESET = 1'b0;
        for (int i = 0; i <= 6; i++) begin
            step();
            chk("rr_set", 8'(bus.SET_srl), 8'(i == 5));
        end
        chk("rr_count", 8'(bus.car_count), 8'd1);

        // asynchronous reset during HOLDOFF
        bus.S0 = 1'b0;
        step();
        bus.S0 = 1'b1;
        step();
        step(); step();
        chk("rh_pre_count", 8'(bus.car_count), 8'd1);
        #2 RESET = 1'b1;
        #1;
        chk("rh_count", 8'(bus.car_count), 8'd0);
        chk("rh_set", 8'(bus.SET_srl), 8'd0);
        chk("rh_wait", 8'(bus.car_waiting), 8'd0);
        @(negedge CLOCK);
        RESET = 1'b0;
        wait_fire("rh_fire_seen");
        step();
        chk("rh_post_count", 8'(bus.car_count), 8'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
